// File: rtl/rca_config_pkg.sv
// Shared RCA configuration types: writeback bundle layout and sequencer state encoding.
package rca_config;

    localparam int RCA_WB_ID_W            = 3;
    localparam int RCA_WB_NUM_WRITE_PORTS = 5;
    localparam int RCA_WB_XLEN            = 32;

    typedef enum logic {
        WB_IDLE  = 1'b0,
        WB_DRAIN = 1'b1
    } rca_wb_state_t;

    // Result bundle as presented by one RCA in the default configuration.
    typedef struct packed {
        logic [RCA_WB_NUM_WRITE_PORTS*RCA_WB_XLEN-1:0] data;
        logic [RCA_WB_NUM_WRITE_PORTS*5-1:0]           dest_addrs;
        logic [RCA_WB_NUM_WRITE_PORTS-1:0]             mask;
        logic [RCA_WB_ID_W-1:0]                        id;
    } rca_wb_bundle_t;

endpackage

// File: rtl/rca_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or above ptr, with wrap.
module rca_rr_arbiter #(
    parameter int NUM_RCAS = 4,
    parameter int PTR_W    = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1
) (
    input  logic [NUM_RCAS-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [NUM_RCAS-1:0] grant,
    output logic [PTR_W-1:0]    grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_RCAS; off++) begin
            idx = (int'(ptr) + off) % NUM_RCAS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rca_result_wb_sequencer.sv
// Round-robin grants one RCA result bundle and serializes it as one register writeback per cycle.
// Optional RCA_WB_PERF_EN adds saturating grant and stall counters.
module rca_result_wb_sequencer
    import rca_config::*;
#(
    parameter int NUM_RCAS        = 4,
    parameter int NUM_WRITE_PORTS = RCA_WB_NUM_WRITE_PORTS,
    parameter int XLEN            = RCA_WB_XLEN,
    parameter int ID_W            = RCA_WB_ID_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_RCAS-1:0]                   res_valid,
    output logic [NUM_RCAS-1:0]                   res_ready,
    input  logic [NUM_RCAS*NUM_WRITE_PORTS*XLEN-1:0] res_data,
    input  logic [NUM_RCAS*NUM_WRITE_PORTS*5-1:0] res_dest_addrs,
    input  logic [NUM_RCAS*NUM_WRITE_PORTS-1:0]   res_wr_mask,
    input  logic [NUM_RCAS*ID_W-1:0]              res_id,
    input  logic                                  flush,
    output logic                                  wb_valid,
    input  logic                                  wb_ack,
    output logic [4:0]                            wb_rd_addr,
    output logic [XLEN-1:0]                       wb_data,
    output logic [ID_W-1:0]                       wb_id,
    output logic                                  wb_last,
    output logic                                  busy
`ifdef RCA_WB_PERF_EN
    ,
    output logic [31:0]                           perf_bundles,
    output logic [31:0]                           perf_stall_cycles
`endif
);

    localparam int PTR_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;
    localparam int NWP   = NUM_WRITE_PORTS;

    rca_wb_state_t state_q, state_d;

    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     grant_idx;
    logic [NUM_RCAS-1:0]  grant;
    logic                 grant_fire;

    logic [NWP*XLEN-1:0]  buf_data_q;
    logic [NWP*5-1:0]     buf_addrs_q;
    logic [NWP-1:0]       buf_mask_q;
    logic [ID_W-1:0]      buf_id_q;

    logic [NWP*XLEN-1:0]  sel_data;
    logic [NWP*5-1:0]     sel_addrs;
    logic [NWP-1:0]       sel_mask;
    logic [ID_W-1:0]      sel_id;
    logic [NWP-1:0]       eff_mask;

    logic [NWP-1:0]       beat_oh;
    logic                 beat_found;
    logic                 beat_last;
    logic                 beat_done;
    int                   beat_sel;
    int                   g;

    rca_rr_arbiter #(
        .NUM_RCAS (NUM_RCAS),
        .PTR_W    (PTR_W)
    ) u_arb (
        .req       (res_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign grant_fire = !rst && !flush && (state_q == WB_IDLE) && (|res_valid);
    assign beat_done  = (state_q == WB_DRAIN) && wb_ack && !flush;

    // Slice the granted requester's payload; ports writing x0 are dropped from the mask.
    always_comb begin
        g         = int'(grant_idx);
        sel_data  = res_data[g*NWP*XLEN +: NWP*XLEN];
        sel_addrs = res_dest_addrs[g*NWP*5 +: NWP*5];
        sel_mask  = res_wr_mask[g*NWP +: NWP];
        sel_id    = res_id[g*ID_W +: ID_W];
        eff_mask  = '0;
        for (int p = 0; p < NWP; p++) begin
            eff_mask[p] = sel_mask[p] && (sel_addrs[p*5 +: 5] != 5'd0);
        end
    end

    // Lowest remaining port goes first, so duplicate destinations resolve to the highest port.
    always_comb begin
        beat_oh    = '0;
        beat_found = 1'b0;
        beat_sel   = 0;
        for (int p = 0; p < NWP; p++) begin
            if (!beat_found && buf_mask_q[p]) begin
                beat_found  = 1'b1;
                beat_sel    = p;
                beat_oh[p]  = 1'b1;
            end
        end
        beat_last = ((buf_mask_q & ~beat_oh) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: begin
                if (grant_fire) state_d = WB_DRAIN;
            end
            WB_DRAIN: begin
                if (flush)                      state_d = WB_IDLE;
                else if (wb_ack && beat_last)   state_d = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        res_ready  = grant_fire ? grant : '0;
        busy       = (state_q == WB_DRAIN);
        wb_valid   = 1'b0;
        wb_last    = 1'b0;
        wb_rd_addr = 5'd0;
        wb_data    = '0;
        wb_id      = '0;
        if (state_q == WB_DRAIN) begin
            wb_valid = 1'b1;
            wb_last  = beat_last;
            wb_id    = buf_id_q;
            if (beat_found) begin
                wb_rd_addr = buf_addrs_q[beat_sel*5 +: 5];
                wb_data    = buf_data_q[beat_sel*XLEN +: XLEN];
            end
        end
    end

    // A flushed bundle is simply forgotten; the RCA already saw its ready and will not replay it.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            buf_mask_q  <= '0;
            buf_data_q  <= '0;
            buf_addrs_q <= '0;
            buf_id_q    <= '0;
        end else if (flush) begin
            buf_mask_q <= '0;
        end else if (grant_fire) begin
            buf_data_q  <= sel_data;
            buf_addrs_q <= sel_addrs;
            buf_mask_q  <= eff_mask;
            buf_id_q    <= sel_id;
            rr_ptr_q    <= (grant_idx == PTR_W'(NUM_RCAS - 1)) ? '0 : grant_idx + 1'b1;
        end else if (beat_done) begin
            buf_mask_q <= buf_mask_q & ~beat_oh;
        end
    end

`ifdef RCA_WB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bundles      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (grant_fire && (perf_bundles != '1))
                perf_bundles <= perf_bundles + 32'd1;
            if (wb_valid && !wb_ack && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/rca_result_wb_sequencer.md
Name: rca_result_wb_sequencer

Overview:
Shares the single RCA writeback path between NUM_RCAS accelerators. Each RCA, on completing a use instruction, presents a result bundle of up to NUM_WRITE_PORTS results. The bundle carries per-port destination addresses (from rca_config_t.rca_cpu_dest_reg_addrs) and a write mask. The block round-robin grants one bundle, buffers it, and serializes it as one-register-per-cycle writebacks into the core writeback/commit logic, flagging the final beat so the instruction id retires.

Parameters:
NUM_RCAS, 4, number of RCA requesters (≥1)
NUM_WRITE_PORTS, 5, result ports per bundle (≥1)
XLEN, 32, data width
ID_W, 3, width of instruction id (matches id_t)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
res_valid  in  NUM_RCAS  bundle offered by RCA i
res_ready  out  NUM_RCAS  bundle i accepted this cycle (one-hot or zero)
res_data  in  NUM_RCAS*NUM_WRITE_PORTS*XLEN  result values
res_dest_addrs  in  NUM_RCAS*NUM_WRITE_PORTS*5  destination register per port
res_wr_mask  in  NUM_RCAS*NUM_WRITE_PORTS  port p produces a result
res_id  in  NUM_RCAS*ID_W  id of the use instruction
flush  in  1  discard the buffered bundle (gc flush)
wb_valid  out  1  writeback beat valid
wb_ack  in  1  writeback accepted
wb_rd_addr  out  5  destination register; 0 on retire-only beat
wb_data  out  XLEN  value
wb_id  out  ID_W  instruction id
wb_last  out  1  final beat of bundle
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE, rr pointer=0, buffer mask=0. All outputs are 0: res_ready, wb_valid, wb_last, wb_rd_addr, wb_data, wb_id, busy.
- States: IDLE, DRAIN.
- IDLE grant rule:
  - res_ready is combinational. It selects the first valid i searching from rr_ptr upward, with wrap.
  - Buffer captures data, addrs, id and effective mask on the edge. Effective mask = res_wr_mask & (dest addr != 0).
  - rr_ptr <= grant+1 mod NUM_RCAS.
  - Next state is DRAIN.
- Handshake: an RCA holds res_valid and payload stable until its res_ready. res_ready is never asserted while flush=1 or in DRAIN.
- DRAIN, one beat per cycle:
  - The beat presents the lowest-index set bit p of the buffer mask. wb_rd_addr=addr[p], wb_data=data[p], wb_id=buffered id.
  - wb_last=1 when p is the only set bit.
  - On wb_valid&&wb_ack, clear bit p.
  - If the beat was last, go to IDLE. A new grant can occur the cycle after, giving a 1-cycle bubble between bundles.
  - wb_valid stays high and payload stays stable until ack.
- Empty effective mask: one retire-only beat with wb_rd_addr=0, wb_data=0, wb_last=1.
- Latency: res_valid/res_ready at cycle N → first wb_valid at N+1. A k-register bundle with continuous ack completes at N+k.
- flush in any state:
  - Next state IDLE, buffer mask cleared. wb_valid drops the next cycle.
  - A granted bundle is not replayed.
  - flush and wb_ack in the same cycle: flush wins, and the beat counts as not written.
- Requester deasserting res_valid without res_ready: it loses its turn, and rr_ptr is unchanged.
- Duplicate dest addrs within a bundle are written in port order, so the last port wins.
- Reset mid-DRAIN: the buffer is discarded, same as flush.

Optional Feature:
RCA_WB_PERF_EN
- When defined, adds two outputs: perf_bundles (32b, increments on each grant) and perf_stall_cycles (32b, increments each cycle wb_valid&&!wb_ack). Both are cleared by rst and saturate at all-ones.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- rca_config package gains:
  - rca_wb_bundle_t (data, dest addrs, mask, id)
  - RCA_WB_ID_W
- Sub-module rca_rr_arbiter (NUM_RCAS, combinational one-hot grant from request + pointer) is instantiated once. The sequencer owns the pointer register.

Test Plan:
- Single bundle: RCA0, mask=5'b10110, addrs {x5,x6,x7,x0,x9}, id=2, ack always 1 → grant at N. Beats (x6,N+1), (x7,N+2), (x9,N+3, wb_last=1), all with wb_id=2. Next cycle busy=0.
- Fairness: RCA0..3 all valid continuously → grant order 0,1,2,3,0. No requester is granted twice before all others.
- Backpressure: wb_ack held 0 for 4 cycles on first beat → wb_valid stays 1 with payload stable. perf_stall_cycles=4 when RCA_WB_PERF_EN is defined.
- Zero-write bundle: mask=0 (or all addrs x0) → exactly one beat with wb_rd_addr=0, wb_last=1, then IDLE.
- Flush mid-drain: flush asserted on second beat of a 3-beat bundle together with wb_ack=1 → wb_valid=0 next cycle, state IDLE, no further beats. A pending RCA1 is granted the cycle after flush deasserts.
- Reset during DRAIN: rst for 1 cycle → all outputs 0 and rr_ptr=0. RCA2 alone valid afterwards → granted first.
